// File: rtl/qspi_mem_responder_pkg.sv
// qspi_mem_responder_pkg: QSPI command codes, responder states and framing constants shared by the QSPI blocks.
package qspi_mem_responder_pkg;
    typedef enum logic [7:0] {
        QSPI_CMD_READ  = 8'hEB,
        QSPI_CMD_WRITE = 8'h38
    } qspi_cmd_e;
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } qspi_resp_state_e;
    localparam int QSPI_CMD_NIBBLES  = 2;
    localparam int QSPI_ADDR_NIBBLES = 6;
endpackage

// File: rtl/qspi_mem_responder_pin_sync.sv
// qspi_pin_sync: two-flop synchronizer for the QSPI pins plus edge pulses on the synced clock and select.
module qspi_pin_sync (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_qspi_clk,
    input  logic       i_qspi_select_n,
    input  logic [3:0] i_qspi_data_in,
    output logic       o_clk_rise,
    output logic       o_clk_fall,
    output logic       o_sel_fall,
    output logic       o_sel_n,
    output logic [3:0] o_data
);
    logic [1:0] r_clk_s, r_sel_s;
    logic [3:0] r_data_s0, r_data_s1;
    logic       r_clk_d, r_sel_d;
    // Select resets low so a select held low across reset never looks like a fresh falling edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_clk_s   <= '0;
            r_sel_s   <= '0;
            r_data_s0 <= '0;
            r_data_s1 <= '0;
            r_clk_d   <= 1'b0;
            r_sel_d   <= 1'b0;
        end else begin
            r_clk_s   <= {r_clk_s[0], i_qspi_clk};
            r_sel_s   <= {r_sel_s[0], i_qspi_select_n};
            r_data_s0 <= i_qspi_data_in;
            r_data_s1 <= r_data_s0;
            r_clk_d   <= r_clk_s[1];
            r_sel_d   <= r_sel_s[1];
        end
    end
    assign o_clk_rise = r_clk_s[1] & ~r_clk_d;
    assign o_clk_fall = ~r_clk_s[1] & r_clk_d;
    assign o_sel_fall = ~r_sel_s[1] & r_sel_d;
    assign o_sel_n    = r_sel_s[1];
    assign o_data     = r_data_s1;
endmodule

// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder: quad-SPI target decoding command/address nibbles and serving a byte-wide memory port.
module qspi_mem_responder
    import qspi_mem_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DUMMY_CYCLES  = 4,
    parameter bit READ_ONLY     = 1'b0
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_qspi_clk,
    input  logic                     i_qspi_select_n,
    input  logic [3:0]               i_qspi_data_in,
    output logic [3:0]               o_qspi_data_out,
    output logic                     o_qspi_data_oe,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic [7:0]               o_mem_wdata,
    output logic                     o_mem_we,
    output logic                     o_mem_re,
    input  logic [7:0]               i_mem_rdata
);
    logic                     w_clk_rise, w_clk_fall, w_sel_fall, w_sel_n, w_drive_hi;
    logic [3:0]               w_data;
    logic [7:0]               w_cmd;
    logic [ADDRESS_WIDTH-1:0] w_addr_next;
    qspi_resp_state_e         r_state;
    logic [7:0]               r_cnt;
    logic [3:0]               r_cmd_hi, r_wr_hi, r_cur_lo;
    logic [ADDRESS_WIDTH-1:0] r_addr_sh;
    logic [7:0]               r_prefetch;
    logic                     r_is_read, r_nib_lo, r_half, r_re_d, r_wr_inc;

    qspi_pin_sync u_sync (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_qspi_clk      (i_qspi_clk),
        .i_qspi_select_n (i_qspi_select_n),
        .i_qspi_data_in  (i_qspi_data_in),
        .o_clk_rise      (w_clk_rise),
        .o_clk_fall      (w_clk_fall),
        .o_sel_fall      (w_sel_fall),
        .o_sel_n         (w_sel_n),
        .o_data          (w_data)
    );

    assign w_cmd       = {r_cmd_hi, w_data};
    assign w_addr_next = ADDRESS_WIDTH'({r_addr_sh, w_data});
    // High nibble goes out on the fall ending the dummy phase and on every other fall in READ.
    assign w_drive_hi  = w_clk_fall && !w_sel_n &&
                         ((r_state == DUMMY && r_cnt == 8'(DUMMY_CYCLES)) || (r_state == READ && !r_nib_lo));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_cmd_hi        <= '0;
            r_wr_hi         <= '0;
            r_cur_lo        <= '0;
            r_addr_sh       <= '0;
            r_prefetch      <= '0;
            r_is_read       <= 1'b0;
            r_nib_lo        <= 1'b0;
            r_half          <= 1'b0;
            r_re_d          <= 1'b0;
            r_wr_inc        <= 1'b0;
            o_qspi_data_out <= '0;
            o_qspi_data_oe  <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
            o_mem_we        <= 1'b0;
            o_mem_re        <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_mem_re <= 1'b0;
            r_re_d   <= o_mem_re;
            r_wr_inc <= 1'b0;
            if (r_re_d) r_prefetch <= i_mem_rdata;
            if (r_wr_inc) o_mem_addr <= o_mem_addr + ADDRESS_WIDTH'(1);
            if (r_state != IDLE && w_sel_n) begin
                r_state        <= IDLE;
                r_half         <= 1'b0;
                o_qspi_data_oe <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_sel_fall) begin
                        r_state   <= CMD;
                        r_cnt     <= '0;
                        r_half    <= 1'b0;
                        r_addr_sh <= '0;
                    end
                    CMD: if (w_clk_rise) begin
                        r_cmd_hi <= w_data;
                        r_cnt    <= r_cnt + 8'd1;
                        if (r_cnt == 8'(QSPI_CMD_NIBBLES - 1)) begin
                            r_cnt     <= '0;
                            r_is_read <= (w_cmd == QSPI_CMD_READ);
                            r_state   <= (w_cmd == QSPI_CMD_READ || w_cmd == QSPI_CMD_WRITE) ? ADDR : IGNORE;
                        end
                    end
                    ADDR: if (w_clk_rise) begin
                        r_addr_sh <= w_addr_next;
                        r_cnt     <= r_cnt + 8'd1;
                        if (r_cnt == 8'(QSPI_ADDR_NIBBLES - 1)) begin
                            r_cnt      <= '0;
                            o_mem_addr <= w_addr_next;
                            o_mem_re   <= r_is_read;
                            r_state    <= r_is_read ? DUMMY : WRITE;
                        end
                    end
                    DUMMY: begin
                        if (w_clk_rise) r_cnt <= r_cnt + 8'd1;
                        if (w_drive_hi) r_state <= READ;
                    end
                    READ: if (w_clk_fall && r_nib_lo) begin
                        o_qspi_data_out <= r_cur_lo;
                        r_nib_lo        <= 1'b0;
                    end
                    WRITE: if (w_clk_rise) begin
                        r_half <= !r_half;
                        if (!r_half) r_wr_hi <= w_data;
                        else begin
                            o_mem_wdata <= {r_wr_hi, w_data};
                            o_mem_we    <= ~READ_ONLY;
                            r_wr_inc    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (w_drive_hi) begin
                    o_qspi_data_oe  <= 1'b1;
                    o_qspi_data_out <= r_prefetch[7:4];
                    r_cur_lo        <= r_prefetch[3:0];
                    r_nib_lo        <= 1'b1;
                    o_mem_addr      <= o_mem_addr + ADDRESS_WIDTH'(1);
                    o_mem_re        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_mem_responder.sv
// tb_qspi_mem_responder: table-driven and randomized QSPI transactions against a transaction-level memory model.
module tb_qspi_mem_responder;
    import qspi_mem_responder_pkg::*;
    localparam int HALF = 4;
    localparam int DUM  = 4;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        int          extra;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n_we;
        int          n_re;
    } vec_t;

    logic        clk = 1'b0, rst;
    logic        q_clk, q_sel_n;
    logic [3:0]  q_din;
    logic [3:0]  dout, ro_dout;
    logic        oe, ro_oe;
    logic [15:0] mem_addr, ro_addr;
    logic [7:0]  mem_wdata, ro_wdata, mem_rdata, ro_rdata;
    logic        mem_we, mem_re, ro_we, ro_re;

    logic [7:0]  sim_mem [65536];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    logic [31:0] act_we[$];
    logic [31:0] act_re[$];
    logic [7:0]  v;
    int          n_tests = 0, n_fail = 0, overlap = 0, ro_we_cnt = 0, bad_oe = 0;
    vec_t        vt [6];

    always #5 clk = ~clk;

    qspi_mem_responder #(.ADDRESS_WIDTH(16), .DUMMY_CYCLES(DUM), .READ_ONLY(1'b0)) dut (
        .i_clock(clk), .i_reset(rst), .i_qspi_clk(q_clk), .i_qspi_select_n(q_sel_n),
        .i_qspi_data_in(q_din), .o_qspi_data_out(dout), .o_qspi_data_oe(oe),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
    );

    qspi_mem_responder #(.ADDRESS_WIDTH(16), .DUMMY_CYCLES(DUM), .READ_ONLY(1'b1)) dut_ro (
        .i_clock(clk), .i_reset(rst), .i_qspi_clk(q_clk), .i_qspi_select_n(q_sel_n),
        .i_qspi_data_in(q_din), .o_qspi_data_out(ro_dout), .o_qspi_data_oe(ro_oe),
        .o_mem_addr(ro_addr), .o_mem_wdata(ro_wdata), .o_mem_we(ro_we),
        .o_mem_re(ro_re), .i_mem_rdata(ro_rdata)
    );

    assign ro_rdata = 8'h00;

    always @(posedge clk) begin
        if (mem_we) sim_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sim_mem[mem_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) act_we.push_back({8'h0, mem_addr, mem_wdata});
            if (mem_re) act_re.push_back({16'h0, mem_addr});
            if (mem_we && mem_re) overlap++;
            if (ro_we) ro_we_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic qcycle(input logic [3:0] din, input logic exp_oe, output logic [3:0] d);
        q_clk = 1'b0;
        q_din = din;
        repeat (HALF) @(negedge clk);
        d = dout;
        if (oe !== exp_oe) bad_oe++;
        q_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic start_sel();
        act_we.delete();
        act_re.delete();
        bad_oe  = 0;
        q_sel_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_sel();
        q_clk   = 1'b0;
        q_sel_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n, input int extra);
        logic [3:0] d, hi;
        start_sel();
        qcycle(cmd[7:4], 1'b0, d);
        qcycle(cmd[3:0], 1'b0, d);
        if (cmd == 8'h38 || cmd == 8'hEB)
            for (int i = 5; i >= 0; i--) qcycle(addr[i*4 +: 4], 1'b0, d);
        if (cmd == 8'h38) begin
            for (int i = 0; i < n; i++) begin
                qcycle(wbuf[i][7:4], 1'b0, d);
                qcycle(wbuf[i][3:0], 1'b0, d);
            end
            if (extra != 0) qcycle(wbuf[n][7:4], 1'b0, d);
        end else if (cmd == 8'hEB) begin
            for (int i = 0; i < DUM; i++) qcycle(4'h0, 1'b0, d);
            for (int i = 0; i < n; i++) begin
                qcycle(4'h0, 1'b1, hi);
                qcycle(4'h0, 1'b1, d);
                rbuf[i] = {hi, d};
            end
        end else begin
            for (int i = 0; i < 8; i++) qcycle(4'($urandom), 1'b0, d);
        end
        end_sel();
    endtask

    // Expected strobes and read bytes from the transaction rules alone: bytes land at
    // consecutive addresses modulo 2^16, and a read fetches one byte ahead of what it returns.
    task automatic model_check(input string tag, input logic [7:0] cmd, input logic [23:0] addr, input int n);
        logic [31:0] ew[$];
        logic [31:0] er[$];
        int a;
        a = int'(addr[15:0]);
        if (cmd == 8'h38) begin
            for (int i = 0; i < n; i++) begin
                ew.push_back({8'h0, 16'(a), wbuf[i]});
                ref_mem[a] = wbuf[i];
                a = (a + 1) % 65536;
            end
        end else if (cmd == 8'hEB) begin
            for (int i = 0; i <= n; i++) begin
                er.push_back({16'h0, 16'(a)});
                if (i < n) check({tag, " rd_byte"}, 32'(rbuf[i]), 32'(ref_mem[a]));
                a = (a + 1) % 65536;
            end
        end
        check({tag, " n_we"}, act_we.size(), ew.size());
        for (int i = 0; i < ew.size() && i < act_we.size(); i++) check({tag, " we_addr_data"}, act_we[i], ew[i]);
        check({tag, " n_re"}, act_re.size(), er.size());
        for (int i = 0; i < er.size() && i < act_re.size(); i++) check({tag, " re_addr"}, act_re[i], er[i]);
        check({tag, " oe_phase_errs"}, bad_oe, 0);
        check({tag, " oe_after"}, 32'(oe), 0);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [3:0]  d;
        int          n, extra, k, ro_before;
        vt[0] = '{8'h38, 24'h000010, 2, 0, 8'hA5, 8'h3C, 2, 0};
        vt[1] = '{8'hEB, 24'h000010, 2, 0, 8'hA5, 8'h3C, 0, 3};
        vt[2] = '{8'hEB, 24'h00FFFF, 2, 0, 8'h12, 8'h34, 0, 3};
        vt[3] = '{8'h9F, 24'h000000, 0, 0, 8'h00, 8'h00, 0, 0};
        vt[4] = '{8'hEB, 24'h000010, 1, 0, 8'hA5, 8'h00, 0, 2};
        vt[5] = '{8'h38, 24'h000020, 0, 1, 8'h70, 8'h00, 0, 0};
        rst = 1'b1; q_clk = 1'b0; q_sel_n = 1'b1; q_din = 4'h0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            sim_mem[i] <= v;
            ref_mem[i] = v;
        end
        sim_mem[16'hFFFF] <= 8'h12; ref_mem[16'hFFFF] = 8'h12;
        sim_mem[16'h0000] <= 8'h34; ref_mem[16'h0000] = 8'h34;
        repeat (4) @(negedge clk);
        check("reset oe", 32'(oe), 0);
        check("reset data_out", 32'(dout), 0);
        check("reset we", 32'(mem_we), 0);
        check("reset re", 32'(mem_re), 0);
        check("reset addr", 32'(mem_addr), 0);
        check("reset wdata", 32'(mem_wdata), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            wbuf[0] = vt[r].b0;
            wbuf[1] = vt[r].b1;
            run_txn(vt[r].cmd, vt[r].addr, vt[r].n, vt[r].extra);
            check("tbl n_we", act_we.size(), vt[r].n_we);
            check("tbl n_re", act_re.size(), vt[r].n_re);
            if (vt[r].cmd == 8'hEB) begin
                check("tbl rd0", 32'(rbuf[0]), 32'(vt[r].b0));
                if (vt[r].n > 1) check("tbl rd1", 32'(rbuf[1]), 32'(vt[r].b1));
            end
            model_check("tbl", vt[r].cmd, vt[r].addr, vt[r].n);
        end

        wbuf[0] = 8'h55;
        ro_before = ro_we_cnt;
        run_txn(8'h38, 24'h000030, 1, 0);
        check("ro we_count", ro_we_cnt - ro_before, 0);
        check("ro addr_after", 32'(ro_addr), 32'h0031);
        check("rw addr_after", 32'(mem_addr), 32'h0031);
        model_check("ro_main", 8'h38, 24'h000030, 1);

        start_sel();
        qcycle(4'hE, 1'b0, d);
        qcycle(4'hB, 1'b0, d);
        for (int i = 0; i < 6; i++) qcycle((i == 4) ? 4'h1 : 4'h0, 1'b0, d);
        for (int i = 0; i < DUM; i++) qcycle(4'h0, 1'b0, d);
        qcycle(4'h0, 1'b1, d);
        check("midrd hi_nibble", 32'(d), 32'(ref_mem[16'h0010][7:4]));
        act_we.delete();
        act_re.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrd oe_after_reset", 32'(oe), 0);
        for (int i = 0; i < 8; i++) qcycle(4'($urandom), 1'b0, d);
        end_sel();
        check("midrd n_we", act_we.size(), 0);
        check("midrd n_re", act_re.size(), 0);
        check("midrd oe_errs", bad_oe, 0);
        run_txn(8'hEB, 24'h000010, 1, 0);
        model_check("post_reset", 8'hEB, 24'h000010, 1);

        for (int t = 0; t < 24; t++) begin
            k = $urandom_range(0, 2);
            if (k == 0) cmd = 8'h38;
            else if (k == 1) cmd = 8'hEB;
            else begin
                cmd = 8'($urandom);
                while (cmd == 8'hEB || cmd == 8'h38) cmd = 8'($urandom);
            end
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr[15:0] = 16'hFFFF - 16'($urandom_range(0, 2));
            n = $urandom_range(1, 3);
            extra = (cmd == 8'h38) ? int'($urandom_range(0, 1)) : 0;
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            run_txn(cmd, addr, n, extra);
            model_check("rnd", cmd, addr, n);
        end

        check("we_re_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI target. It is the far end of the link driven by the mem controller's QSPI initiator.
- Decodes quad-mode command, address and data nibbles from the initiator and serves reads and writes from a generic synchronous memory port.
- Used as a drop-in bus responder (RAM A/B or flash image) for FPGA bring-up and gate-level benches.
- Oversamples the QSPI pins on the single system clock.

Parameters:
- ADDRESS_WIDTH, 16: width of mem_addr; the low ADDRESS_WIDTH bits of the 24-bit QSPI address are used.
- DUMMY_CYCLES, 4: qspi_clk cycles between the last address nibble and the first read data nibble; must be ≥2.
- READ_ONLY, 0: 1 = write command is accepted and then ignored (flash behaviour); mem_we is never asserted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- qspi_clk  in  1  serial clock from initiator
- qspi_select_n  in  1  chip select, active low
- qspi_data_in  in  4  nibble driven by initiator
- qspi_data_out  out  4  nibble driven by responder
- qspi_data_oe  out  1  responder drives the data lines
- mem_addr  out  ADDRESS_WIDTH  backing-store byte address
- mem_wdata  out  8  write byte
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  8  read byte, valid the cycle after mem_re

Behaviour:
Clocking and sampling:
- One clock (clock); reset is synchronous and active-high.
- qspi_clk, qspi_select_n and qspi_data_in each pass through a 2-flop synchronizer. All three are delayed equally.
- The rising edge of the synced qspi_clk samples input. The falling edge updates output.
- Requirement on the initiator: qspi_clk high and low phases each ≥3 clock periods.

Reset values:
- qspi_data_out=0, qspi_data_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, state=IDLE, all counters 0.

Framing:
- All fields are MSB nibble first.
- Command: 2 nibbles. Address: 6 nibbles (24 bits).
- Commands: 0xEB = quad read, 0x38 = quad write. Any other command goes to IGNORE.

State machine:
- IDLE: a falling edge of select (select_n 1→0) goes to CMD, nibble counter=0.
- CMD: after 2 rising edges, decode the command into ADDR, or into IGNORE for an unknown command.
- ADDR: after 6 rising edges, load the address register.
  - Read: pulse mem_re the following cycle, then go to DUMMY.
  - Write: go to WRITE.
- DUMMY: count DUMMY_CYCLES rising edges.
  - Capture mem_rdata into the output byte register the cycle after mem_re.
  - On the falling edge that ends the last dummy cycle, assert oe and drive the high nibble. Go to READ.
- READ: each falling edge drives the next nibble (high, low, high, ...).
  - When the high nibble is driven, increment the address and pulse mem_re.
  - Load the prefetched byte into the output register before the next high nibble.
  - Continues indefinitely.
- WRITE: two rising edges assemble a byte.
  - On the low nibble, pulse mem_we for 1 cycle with the current address and byte.
  - Then increment the address.
  - If READ_ONLY, do not pulse mem_we.
- IGNORE: oe=0; wait for deselect.

Boundaries:
- Select deasserted in any state: next cycle go to IDLE, oe=0, no further strobes.
  - A partial write byte is discarded.
  - A strobe already issued is not retracted.
- Address wrap: increments modulo 2^ADDRESS_WIDTH (0xFFFF→0x0000 at the default width).
- Select high while qspi_clk toggles: ignored.
- Reset mid-transaction returns to IDLE even with select low. The responder does not restart until the next select falling edge.
- mem_we and mem_re are never asserted in the same cycle.

Decomposition:
- Shared package (same package as the mem controller enums) holds:
  - qspi_cmd_e: QSPI_CMD_READ=8'hEB, QSPI_CMD_WRITE=8'h38.
  - qspi_resp_state_e: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
  - QSPI_ADDR_NIBBLES=6.
- One sub-module, qspi_pin_sync: the 2-flop synchronizer plus clk rise/fall and select fall pulse detection. The responder FSM consumes only these pulses.

Test Plan:
1. Write 0x38, addr 0x000010, data 0xA5,0x3C then deselect → mem_we pulses twice: (0x0010, 0xA5), then (0x0011, 0x3C).
2. Read 0xEB, addr 0x000010, 4 dummy, 2 bytes with mem model holding 0xA5,0x3C → oe rises after the dummy phase; nibbles A,5,3,C sampled on rising edges; mem_re addresses 0x0010, 0x0011, 0x0012.
3. Read at addr 0x00FFFF for 2 bytes → second byte is fetched from 0x0000.
4. Command 0x9F then 8 clocks → no mem_re or mem_we, oe stays 0; a following 0xEB transaction reads correctly.
5. Write 0x38, addr 0x000020, one nibble 0x7, then deselect → no mem_we; state returns to IDLE; oe=0.
6. READ_ONLY=1: write of 0x55 to 0x0030 → mem_we never asserted. reset=1 mid-read → oe=0 next cycle, no strobes until a new select falling edge.
